// File: rtl/sirv_debug_progbuf.sv
// Debug program buffer shared by the DMI port and the hart.
// DMI accesses are combinational; hart accesses use a valid/ready port.
module sirv_debug_progbuf #(
    parameter int DW    = 32,
    parameter int DEPTH = 7,
    parameter int AW    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dmi_cs,
    input  logic            dmi_rd,
    input  logic [AW-1:0]   dmi_addr,
    input  logic [DW-1:0]   dmi_wdat,
    output logic [DW-1:0]   dmi_dout,
    output logic            dmi_err,
    input  logic            icb_cmd_valid,
    output logic            icb_cmd_ready,
    input  logic            icb_cmd_read,
    input  logic [AW-1:0]   icb_cmd_addr,
    input  logic [DW-1:0]   icb_cmd_wdata,
    input  logic [DW/8-1:0] icb_cmd_wmask,
    output logic            icb_rsp_valid,
    input  logic            icb_rsp_ready,
    output logic [DW-1:0]   icb_rsp_rdata,
    output logic            icb_rsp_err,
    input  logic            go,
    input  logic            done,
    output logic            busy
);

    localparam int NB = DW / 8;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          busy_q, busy_d;
    logic          dmi_err_q, dmi_err_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic          cmd_hs;
    logic          hart_in_rng;
    logic          hart_wr;
    logic          dmi_in_rng;
    logic          dmi_wr_req;
    logic          dmi_wr_ok;
    logic [DW-1:0] hart_rd_data;

    assign icb_cmd_ready = ~rsp_valid_q | icb_rsp_ready;
    assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;
    assign hart_in_rng   = {1'b0, icb_cmd_addr} < DEPTH_W;
    assign dmi_in_rng    = {1'b0, dmi_addr} < DEPTH_W;
    assign hart_wr       = cmd_hs & ~icb_cmd_read & hart_in_rng;
    assign dmi_wr_req    = dmi_cs & ~dmi_rd;
    // Hart wins a same-entry collision; busy and range also block the DMI.
    assign dmi_wr_ok     = dmi_wr_req & ~busy_q & dmi_in_rng
                         & ~(hart_wr & (icb_cmd_addr == dmi_addr));

    assign dmi_err       = dmi_err_q;
    assign busy          = busy_q;
    assign icb_rsp_valid = rsp_valid_q;
    assign icb_rsp_rdata = rsp_rdata_q;
    assign icb_rsp_err   = rsp_err_q;

    // Combinational read muxes for the DMI and hart ports
    always_comb begin
        dmi_dout     = '0;
        hart_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (dmi_addr == AW'(i)) dmi_dout = mem_q[i];
            if (icb_cmd_addr == AW'(i)) hart_rd_data = mem_q[i];
        end
    end

    // Next-state for storage, interlock, error pulse and response buffer
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (dmi_wr_ok && dmi_addr == AW'(i)) mem_d[i] = dmi_wdat;
            if (hart_wr && icb_cmd_addr == AW'(i)) begin
                for (int b = 0; b < NB; b++) begin
                    if (icb_cmd_wmask[b])
                        mem_d[i][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
                end
            end
        end

        busy_d = busy_q;
        if (go)        busy_d = 1'b1;
        else if (done) busy_d = 1'b0;

        dmi_err_d = dmi_wr_req & ~dmi_wr_ok;

        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (cmd_hs) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = ~hart_in_rng;
            rsp_rdata_d = (icb_cmd_read && hart_in_rng) ? hart_rd_data : '0;
        end else if (icb_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q      <= 1'b0;
            dmi_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            busy_q      <= busy_d;
            dmi_err_q   <= dmi_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_sirv_debug_progbuf.sv
// Scoreboard bench for sirv_debug_progbuf: stimulus pushes expected
// hart responses, a monitor pops them on each response handshake.
module tb_sirv_debug_progbuf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmi_cs, dmi_rd;
    logic [2:0]  dmi_addr;
    logic [31:0] dmi_wdat, dmi_dout;
    logic        dmi_err;
    logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [2:0]  icb_cmd_addr;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid, icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        go, done, busy;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sirv_debug_progbuf #(.DW(32), .DEPTH(7), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .dmi_cs(dmi_cs), .dmi_rd(dmi_rd), .dmi_addr(dmi_addr),
        .dmi_wdat(dmi_wdat), .dmi_dout(dmi_dout), .dmi_err(dmi_err),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
        .go(go), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every response handshake
    always @(negedge clk) begin
        if (rst_n && icb_rsp_valid && icb_rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", icb_rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, icb_rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dmi_write(input logic [2:0] a, input logic [31:0] d);
        dmi_cs   = 1'b1;
        dmi_rd   = 1'b0;
        dmi_addr = a;
        dmi_wdat = d;
        tick();
        dmi_cs   = 1'b0;
        dmi_rd   = 1'b1;
    endtask

    task automatic hart(input logic rd, input logic [2:0] a,
                        input logic [31:0] wd, input logic [3:0] m,
                        input logic [31:0] er, input logic ee);
        int n;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = a;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = m;
        n = 0;
        while (!icb_cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("cmd_ready_timeout", 32'd0, 32'd1);
        exp_q.push_back('{rdata: er, err: ee});
        tick();
        icb_cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        dmi_cs = 1'b0; dmi_rd = 1'b1; dmi_addr = '0; dmi_wdat = '0;
        icb_cmd_valid = 1'b0; icb_cmd_read = 1'b1; icb_cmd_addr = '0;
        icb_cmd_wdata = '0; icb_cmd_wmask = '0; icb_rsp_ready = 1'b1;
        go = 1'b0; done = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dmi_err", {31'd0, dmi_err}, 32'd0);
        chk("rst_rsp_valid", {31'd0, icb_rsp_valid}, 32'd0);
        chk("rst_cmd_ready", {31'd0, icb_cmd_ready}, 32'd1);
        chk("rst_dout0", dmi_dout, 32'd0);

        // Basic DMI write then hart read
        dmi_write(3'd3, 32'h0010_0073);
        chk("dmi_err_ok3", {31'd0, dmi_err}, 32'd0);
        chk("dout3", dmi_dout, 32'h0010_0073);
        hart(1'b1, 3'd3, '0, '0, 32'h0010_0073, 1'b0);
        chk("rsp_valid_lat", {31'd0, icb_rsp_valid}, 32'd1);

        // Byte-masked hart write
        dmi_write(3'd0, 32'hFFFF_FFFF);
        hart(1'b0, 3'd0, 32'h1234_5678, 4'b0101, 32'd0, 1'b0);
        dmi_addr = 3'd0;
        #1;
        chk("dout0_mask", dmi_dout, 32'hFF34_FF78);
        hart(1'b1, 3'd0, '0, '0, 32'hFF34_FF78, 1'b0);

        // Busy interlock
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("busy_set", {31'd0, busy}, 32'd1);
        dmi_write(3'd1, 32'hDEAD_BEEF);
        chk("dmi_err_busy", {31'd0, dmi_err}, 32'd1);
        chk("dout1_kept", dmi_dout, 32'd0);
        tick();
        chk("dmi_err_pulse", {31'd0, dmi_err}, 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("busy_clr", {31'd0, busy}, 32'd0);
        dmi_write(3'd1, 32'hDEAD_BEEF);
        chk("dmi_err_free", {31'd0, dmi_err}, 32'd0);
        chk("dout1_new", dmi_dout, 32'hDEAD_BEEF);
        go = 1'b1; done = 1'b1;
        tick();
        go = 1'b0; done = 1'b0;
        chk("busy_go_wins", {31'd0, busy}, 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("busy_clr2", {31'd0, busy}, 32'd0);

        // Out of range
        hart(1'b1, 3'd7, '0, '0, 32'd0, 1'b1);
        hart(1'b0, 3'd7, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1);
        dmi_write(3'd7, 32'h1111_1111);
        chk("dmi_err_oor", {31'd0, dmi_err}, 32'd1);
        chk("dout7", dmi_dout, 32'd0);

        // Backpressure with two queued reads
        icb_rsp_ready = 1'b0;
        hart(1'b1, 3'd3, '0, '0, 32'h0010_0073, 1'b0);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = 3'd0;
        #1;
        chk("stall_ready", {31'd0, icb_cmd_ready}, 32'd0);
        chk("stall_rdata", icb_rsp_rdata, 32'h0010_0073);
        tick();
        chk("stall_valid2", {31'd0, icb_rsp_valid}, 32'd1);
        chk("stall_rdata2", icb_rsp_rdata, 32'h0010_0073);
        chk("stall_ready2", {31'd0, icb_cmd_ready}, 32'd0);
        icb_rsp_ready = 1'b1;
        exp_q.push_back('{rdata: 32'hFF34_FF78, err: 1'b0});
        tick();
        icb_cmd_valid = 1'b0;
        chk("second_valid", {31'd0, icb_rsp_valid}, 32'd1);
        chk("second_rdata", icb_rsp_rdata, 32'hFF34_FF78);
        tick();
        chk("ready_after", {31'd0, icb_cmd_ready}, 32'd1);
        chk("idle_after", {31'd0, icb_rsp_valid}, 32'd0);

        // Back-to-back full throughput
        begin
            logic [2:0]  a_tab [3];
            logic [31:0] d_tab [3];
            a_tab = '{3'd0, 3'd1, 3'd3};
            d_tab = '{32'hFF34_FF78, 32'hDEAD_BEEF, 32'h0010_0073};
            icb_cmd_valid = 1'b1;
            icb_cmd_read  = 1'b1;
            for (int i = 0; i < 3; i++) begin
                icb_cmd_addr = a_tab[i];
                #1;
                chk("b2b_ready", {31'd0, icb_cmd_ready}, 32'd1);
                exp_q.push_back('{rdata: d_tab[i], err: 1'b0});
                tick();
                chk("b2b_valid", {31'd0, icb_rsp_valid}, 32'd1);
            end
            icb_cmd_valid = 1'b0;
            tick();
        end

        // Same-cycle DMI and hart write to one entry
        dmi_cs   = 1'b1;
        dmi_rd   = 1'b0;
        dmi_addr = 3'd2;
        dmi_wdat = 32'hAAAA_AAAA;
        hart(1'b0, 3'd2, 32'h5555_5555, 4'hF, 32'd0, 1'b0);
        dmi_cs = 1'b0;
        dmi_rd = 1'b1;
        chk("collide_err", {31'd0, dmi_err}, 32'd1);
        chk("collide_data", dmi_dout, 32'h5555_5555);
        tick();

        // Reset in the middle of a pending response
        go = 1'b1;
        tick();
        go = 1'b0;
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = 3'd2;
        tick();
        icb_cmd_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, icb_rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, icb_rsp_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            dmi_addr = 3'(i);
            #1;
            chk("mid_rst_entry", dmi_dout, 32'd0);
        end
        exp_q.delete();
        icb_rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        hart(1'b1, 3'd0, '0, '0, 32'd0, 1'b0);

        // Drain scoreboard
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                tick();
                n++;
            end
            if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
